// File: rtl/mem_arbiter.sv
// mem_arbiter: N-way TX arbiter for memory_interface
// with an owner-tagged read-tracking FIFO that steers RX strobes.
module mem_arbiter #(
  parameter int NUM_CH = 3,
  parameter int IO_BITS = 2,
  parameter int CMD_BITS = 4,
  parameter logic [CMD_BITS-1:0] READ_CMD = '0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE = 0,
  localparam int OW = $clog2(NUM_CH),
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          ch_cmd_valid,
  input  logic [NUM_CH*CMD_BITS-1:0] ch_cmd,
  input  logic [NUM_CH*IO_BITS-1:0]  ch_tx_data,
  input  logic [NUM_CH-1:0]          ch_reply_wanted,
  input  logic [NUM_CH-1:0]          ch_reserve,
  output logic                       tx_command_valid,
  output logic [CMD_BITS-1:0]        tx_command,
  output logic [IO_BITS-1:0]         tx_data,
  input  logic                       tx_command_started,
  input  logic                       tx_active,
  input  logic                       tx_data_next,
  input  logic                       tx_done,
  input  logic                       rx_started,
  input  logic                       rx_active,
  input  logic                       rx_sbs_valid,
  input  logic                       rx_data_valid,
  input  logic                       rx_done,
  output logic [NUM_CH-1:0]          ch_tx_started,
  output logic [NUM_CH-1:0]          ch_tx_active,
  output logic [NUM_CH-1:0]          ch_tx_data_next,
  output logic [NUM_CH-1:0]          ch_tx_done,
  output logic [NUM_CH-1:0]          ch_rx_started,
  output logic [NUM_CH-1:0]          ch_rx_active,
  output logic [NUM_CH-1:0]          ch_rx_sbs_valid,
  output logic [NUM_CH-1:0]          ch_rx_data_valid,
  output logic [NUM_CH-1:0]          ch_rx_done,
  output logic [OW-1:0]              tx_owner,
  output logic [CW-1:0]              outstanding,
  output logic                       full,
  output logic                       empty,
  output logic                       rx_unexpected
);

  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;

  logic [OW-1:0]       owner_q;
  logic [OW-1:0]       rr_ptr;
  logic                reserve_q;
  logic [OW-1:0]       choice;
  logic [OW-1:0]       sel;
  logic [NUM_CH-1:0]   req;
  logic [CMD_BITS-1:0] sel_cmd;
  logic [IO_BITS-1:0]  sel_data;
  logic                is_read;
  logic                push;
  logic                pop;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count_q;
  logic                ent_valid [MAX_OUTSTANDING];
  logic [OW-1:0]       ent_id    [MAX_OUTSTANDING];
  logic                head_valid;
  logic [OW-1:0]       head_id;
  logic                head_live;

  assign req = ch_cmd_valid | ch_reserve;

  // Pick the next owner: sticky on reserve, else priority or round-robin.
  always_comb begin : pick
    int idx;
    choice = owner_q;
    idx = 0;
    if (!reserve_q) begin
      if (ARB_MODE == 0) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (req[i]) choice = OW'(i);
        end
      end else begin
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          idx = (int'(rr_ptr) + k) % NUM_CH;
          if (req[idx]) choice = OW'(idx);
        end
      end
    end
  end

  assign sel = tx_active ? owner_q : choice;
  assign tx_owner = sel;

  // Route the selected requester's header and payload.
  always_comb begin
    sel_cmd = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == OW'(i)) begin
        sel_cmd = ch_cmd[i*CMD_BITS +: CMD_BITS];
        sel_data = ch_tx_data[i*IO_BITS +: IO_BITS];
      end
    end
  end

  assign tx_command = sel_cmd;
  assign tx_data = sel_data;
  assign is_read = (sel_cmd == READ_CMD);
  assign tx_command_valid = ch_cmd_valid[sel] && !(full && is_read);

  // Grant holder, round-robin pointer and reservation flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= '0;
      rr_ptr <= '0;
      reserve_q <= 1'b0;
    end else begin
      if (!tx_active) owner_q <= choice;
      if (tx_command_started) begin
        rr_ptr <= (sel == OW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
      end
      if (tx_done && ch_reserve[owner_q]) begin
        reserve_q <= 1'b1;
      end else if (!tx_active && !ch_reserve[owner_q]) begin
        reserve_q <= 1'b0;
      end
    end
  end

  assign empty = (count_q == '0);
  assign full = (count_q == CW'(MAX_OUTSTANDING));
  assign outstanding = count_q;
  assign push = tx_command_started && is_read && !full;
  assign pop = rx_done && !empty;
  assign head_valid = ent_valid[rd_ptr];
  assign head_id = ent_id[rd_ptr];
  assign head_live = head_valid && !empty;

  // Read-tracking FIFO: one entry per read awaiting its response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        ent_valid[i] <= 1'b0;
        ent_id[i] <= '0;
      end
    end else begin
      if (push) begin
        ent_valid[wr_ptr] <= ch_reply_wanted[sel];
        ent_id[wr_ptr] <= sel;
        wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ?
                  '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ?
                  '0 : rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10: count_q <= count_q + 1'b1;
        2'b01: count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // One-hot strobe fan-out to the TX owner and the RX response owner.
  always_comb begin
    ch_tx_started = '0;
    ch_tx_active = '0;
    ch_tx_data_next = '0;
    ch_tx_done = '0;
    ch_rx_started = '0;
    ch_rx_active = '0;
    ch_rx_sbs_valid = '0;
    ch_rx_data_valid = '0;
    ch_rx_done = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset_n && sel == OW'(i)) begin
        ch_tx_started[i] = tx_command_started;
        ch_tx_active[i] = tx_active;
        ch_tx_data_next[i] = tx_data_next;
        ch_tx_done[i] = tx_done;
      end
      if (reset_n && head_live && head_id == OW'(i)) begin
        ch_rx_started[i] = rx_started;
        ch_rx_active[i] = rx_active;
        ch_rx_sbs_valid[i] = rx_sbs_valid;
        ch_rx_data_valid[i] = rx_data_valid;
        ch_rx_done[i] = rx_done;
      end
    end
  end

  assign rx_unexpected = reset_n && rx_started && empty;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised successor to the CPU's two-way TX selection and transaction-type FIFO. It arbitrates up to `NUM_CH` requesters (prefetcher, scheduler, future DMA/debug ports) onto the single `memory_interface` TX channel. It tracks outstanding read transactions in an owner-tagged FIFO and routes each RX response back to the requester that issued it. It sits between the requesters and `memory_interface`, replacing the hand-wired `sc_tx`/`pf_tx` and `sc_rx`/`pf_rx` logic.

## Interface
Parameters:
- `NUM_CH`, 3, number of requesters; 2..8.
- `IO_BITS`, 2, TX/RX data width per cycle.
- `CMD_BITS`, 4, command header width.
- `READ_CMD`, 4'd0, command value that expects a response (tracked).
- `MAX_OUTSTANDING`, 4, tracking FIFO depth; 1..8.
- `ARB_MODE`, 0, 0 = fixed priority (highest index wins), 1 = round-robin.

Ports (per-channel buses: channel i occupies bit i, or slice [i*W +: W]):
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ch_cmd_valid`  in  NUM_CH  requester has a command.
- `ch_cmd`  in  NUM_CH*CMD_BITS  command header.
- `ch_tx_data`  in  NUM_CH*IO_BITS  payload data.
- `ch_reply_wanted`  in  NUM_CH  response to a tracked command is delivered (0 = discard).
- `ch_reserve`  in  NUM_CH  keep the grant after the current transaction.
- `tx_command_valid`, `tx_command`, `tx_data`  out  1/CMD_BITS/IO_BITS  to `memory_interface`.
- `tx_command_started`, `tx_active`, `tx_data_next`, `tx_done`  in  1 each  from `memory_interface`.
- `rx_started`, `rx_active`, `rx_sbs_valid`, `rx_data_valid`, `rx_done`  in  1 each  from `memory_interface`.
- `ch_tx_started`, `ch_tx_active`, `ch_tx_data_next`, `ch_tx_done`  out  NUM_CH each  TX strobes gated to the owner.
- `ch_rx_started`, `ch_rx_active`, `ch_rx_sbs_valid`, `ch_rx_data_valid`, `ch_rx_done`  out  NUM_CH each  RX strobes gated to the response owner.
- `tx_owner`  out  $clog2(NUM_CH)  currently selected requester.
- `outstanding`  out  $clog2(MAX_OUTSTANDING+1)  tracked reads in flight.
- `full`, `empty`  out  1  FIFO status.
- `rx_unexpected`  out  1  one-cycle pulse on `rx_started` while FIFO is empty.

## Operation
- Selection: `sel = tx_active ? owner_q : choice`. `owner_q` loads `choice` every cycle with `tx_active`=0 and holds while `tx_active`=1.
- `choice`:
  - If `reserve_q` is set, `choice` = `owner_q`.
  - Otherwise, `ARB_MODE`=0: the highest-index channel with `ch_cmd_valid` or `ch_reserve`.
  - Otherwise, `ARB_MODE`=1: the first requesting channel at or after `rr_ptr`, scanning upward with wrap.
  - No requester: `choice` = `owner_q`.
- `rr_ptr` becomes `sel+1` (wrapping at NUM_CH) on `tx_command_started`.
- `reserve_q` is set on `tx_done` if `ch_reserve[owner_q]`=1. It clears when the owner drops `ch_reserve` while `tx_active`=0.
- Mux: `tx_command`/`tx_data` come from the `sel` slice.
- `tx_command_valid = ch_cmd_valid[sel] && !(full && ch_cmd[sel]==READ_CMD)`.
  - Full gating holds even if `rx_done` occurs the same cycle.
- TX strobes are one-hot: `ch_tx_x[i] = tx_x && (sel==i)`.
- Tracking: on `tx_command_started` with a tracked command, push the entry {valid=`ch_reply_wanted[sel]`, id=`sel`}. Untracked commands (writes) are not queued.
- RX routing uses the FIFO head: `ch_rx_x[i] = rx_x && head.valid && head.id==i && !empty`. A valid=0 head discards the response.
- Pop on `rx_done`. Simultaneous push and pop leave `outstanding` unchanged and replace the entry correctly.
- `rx_done` with the FIFO empty: no pop, no underflow, count stays 0.

## Timing
- Reset (async assert, sync deassert): `owner_q`=0, `rr_ptr`=0, `reserve_q`=0, FIFO empty.
  - `outstanding`=0, `empty`=1, `full`=0.
  - All `ch_*` strobes 0, `rx_unexpected`=0.
  - `tx_command_valid`=0 until an input request is present.
- Grant latency: 0 cycles. A request while idle is muxed combinationally in the same cycle.
- The grant is stable from `tx_command_started` through `tx_done`.
- FIFO push and pop take effect at the next clock edge. `full`/`empty`/`outstanding` are registered-state derived.
- The head entry stays valid through `rx_done` inclusive, so the owner sees its own `ch_rx_done`.
- Reset mid-transaction discards all outstanding entries. Later RX activity is flagged via `rx_unexpected` and not routed.

## Test plan
- NUM_CH=3, ARB_MODE=0, channels 0 and 2 request read simultaneously -> ch2 granted, `ch_tx_started`=3'b100, `outstanding`=1. The response is routed only to ch2 (`ch_rx_done`=3'b100).
- ARB_MODE=1, all three channels request continuously -> grant order 0,1,2,0. `rr_ptr` wraps after 2.
- MAX_OUTSTANDING=2, issue two reads, no RX -> `full`=1, third read has `tx_command_valid`=0. A write from another channel still starts. After one `rx_done`, the third read starts.
- ch1 holds `ch_reserve`=1 across its read, ch0 requests -> ch1 retains `tx_owner`=1 for its write. ch0 is granted only after `ch_reserve[1]` falls.
- Read with `ch_reply_wanted`=0 followed by a read from ch1 -> first response yields no `ch_rx_*` strobes; second reaches ch1; `outstanding` returns to 0.
- `rx_started` with FIFO empty -> `rx_unexpected` pulses 1 cycle, no strobes. Assert `reset_n`=0 mid-TX -> all outputs return to reset values asynchronously.
